// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one FIR engine across NCH input channels.
// Optional WAIT-state watchdog with timeout_err output is enabled by FIR_SCHED_TIMEOUT_EN.
module fir_channel_scheduler #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*DW-1:0]       ch_data,
  output logic [NCH-1:0]          ch_ready,
  output logic                    eng_start,
  output logic [$clog2(NCH)-1:0]  eng_ch,
  output logic [DW-1:0]           eng_data,
  input  logic                    eng_done,
  input  logic [DW-1:0]           eng_result,
  output logic                    out_valid,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic [DW-1:0]           out_data,
  input  logic                    out_ready,
  output logic                    busy
`ifdef FIR_SCHED_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   last_grant_reg;
  logic [CW-1:0]   ch_reg;
  logic [DW-1:0]   data_reg;
  logic [DW-1:0]   out_data_reg;

  logic [CW-1:0]   grant;
  logic [CW-1:0]   cand;
  logic            grant_found;
  logic [DW-1:0]   grant_data;
  logic            timeout_hit;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant       = last_grant_reg;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(last_grant_reg) + i) % NCH);
      if (!grant_found && ch_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign grant_data = ch_data[int'(grant)*DW +: DW];

  always_comb begin
    ch_ready = '0;
    if (state_reg == IDLE && grant_found) begin
      ch_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          state_next = OUTPUT;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= CW'(NCH - 1);
      ch_reg         <= '0;
      data_reg       <= '0;
      out_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_found) begin
        ch_reg   <= grant;
        data_reg <= grant_data;
      end
      if (state_reg == WAIT && eng_done) begin
        out_data_reg <= eng_result;
      end
      // A timed-out channel still counts as served so the others are not starved.
      if ((state_reg == OUTPUT && out_ready) ||
          (state_reg == WAIT && !eng_done && timeout_hit)) begin
        last_grant_reg <= ch_reg;
      end
    end
  end

  assign eng_start = (state_reg == ISSUE);
  assign eng_ch    = ch_reg;
  assign eng_data  = data_reg;
  assign out_valid = (state_reg == OUTPUT);
  assign out_ch    = ch_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != IDLE);

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_err_reg;

  assign timeout_hit = (state_reg == WAIT) && !eng_done &&
                       (wait_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_hit;
      if (state_reg != WAIT) begin
        wait_cnt_reg <= '0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT only sizes the watchdog, which this build does not have.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed scoreboard bench for fir_channel_scheduler; the engine is modelled inline.
// Expected transactions are queued at stimulus time and popped on eng_start / out_valid.
module tb_fir_channel_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic              eng_start;
  logic [1:0]        eng_ch;
  logic [DW-1:0]     eng_data;
  logic              eng_done;
  logic [DW-1:0]     eng_result;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic              busy;
`ifdef FIR_SCHED_TIMEOUT_EN
  logic              timeout_err;
`endif

  fir_channel_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .eng_start  (eng_start),
    .eng_ch     (eng_ch),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef FIR_SCHED_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [15:0] data;
    logic [15:0] result;
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  int   last_start = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [15:0] v);
    ch_data[k*DW +: DW] = v;
  endtask

  task automatic push(input int ch, input logic [15:0] d, input logic [15:0] r);
    sb.push_back(txn_t'{ch, d, r});
  endtask

  task automatic check_reset_outputs(input string tag);
    $display("[%0d] %s: checking reset values", cyc, tag);
    check({tag, "_ch_ready"},  32'(ch_ready),  32'h0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_out_data"},  32'(out_data),  32'h0);
    check({tag, "_out_ch"},    32'(out_ch),    32'h0);
    check({tag, "_eng_ch"},    32'(eng_ch),    32'h0);
    check({tag, "_eng_data"},  32'(eng_data),  32'h0);
  endtask

  // Waits (bounded) for eng_start, pops the expected transaction and checks the issue fields.
  task automatic wait_start(input int exp_gap);
    int n = 0;
    while (!eng_start && n < 40) begin
      tick();
      n++;
    end
    check("start_seen", 32'(eng_start), 32'h1);
    if (sb.size() > 0) cur = sb.pop_front();
    $display("[%0d] start: eng_ch=%0d eng_data=0x%h (expect ch=%0d data=0x%h)",
             cyc, eng_ch, eng_data, cur.ch, cur.data);
    check("eng_ch",   32'(eng_ch),   32'(cur.ch));
    check("eng_data", 32'(eng_data), 32'(cur.data));
    if (exp_gap > 0) check("start_gap", 32'(cyc - last_start), 32'(exp_gap));
    last_start = cyc;
  endtask

  // Called in the ISSUE cycle. Engine answers elat cycles after the first WAIT cycle;
  // downstream holds off for bp cycles; optionally a stray eng_done is driven in ISSUE.
  task automatic finish_txn(input int elat, input int bp, input bit spurious);
    logic [15:0] held;
    out_ready  = (bp == 0);
    eng_done   = spurious;
    eng_result = 16'hDEAD;
    tick();
    eng_done   = 1'b0;
    check("start_pulse_len", 32'(eng_start), 32'h0);
    check("no_valid_in_wait", 32'(out_valid), 32'h0);
    repeat (elat) tick();
    eng_done   = 1'b1;
    eng_result = cur.result;
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
    $display("[%0d] output: valid=%0d ch=%0d data=0x%h (expect ch=%0d data=0x%h)",
             cyc, out_valid, out_ch, out_data, cur.ch, cur.result);
    check("out_valid", 32'(out_valid), 32'h1);
    check("out_ch",    32'(out_ch),    32'(cur.ch));
    check("out_data",  32'(out_data),  32'(cur.result));
    held = cur.result;
    for (int i = 0; i < bp; i++) begin
      check("bp_valid",    32'(out_valid), 32'h1);
      check("bp_data",     32'(out_data),  32'(held));
      check("bp_ch_ready", 32'(ch_ready),  32'h0);
      check("bp_start",    32'(eng_start), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("idle_busy",  32'(busy),      32'h0);
    check("idle_valid", 32'(out_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1; ch_valid = '0; ch_data = '0;
    eng_done = 1'b0; eng_result = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Stray eng_done while idle
    eng_done = 1'b1; eng_result = 16'hBEEF;
    tick();
    eng_done = 1'b0;
    $display("[%0d] spurious done in IDLE: out_valid=%0d busy=%0d", cyc, out_valid, busy);
    check("idle_spurious_valid", 32'(out_valid), 32'h0);
    check("idle_spurious_busy",  32'(busy),      32'h0);
    tick();
    check("idle_spurious_valid2", 32'(out_valid), 32'h0);

    // Single request on channel 0
    set_data(0, 16'h1234);
    ch_valid = 4'b0001;
    #1;
    check("single_ready", 32'(ch_ready), 32'h1);
    push(0, 16'h1234, 16'h0ABC);
    tick();
    ch_valid = '0;
    check("start_latency", 32'(eng_start), 32'h1);
    wait_start(0);
    finish_txn(4, 0, 1'b0);

    // Channel 2 with a stray eng_done during ISSUE; negative sample passes untouched
    set_data(2, 16'h8001);
    ch_valid = 4'b0100;
    #1;
    check("ch2_ready", 32'(ch_ready), 32'h4);
    push(2, 16'h8001, 16'hF00D);
    tick();
    ch_valid = '0;
    wait_start(0);
    finish_txn(1, 0, 1'b1);

    // Backpressure with every channel requesting: grant rotates to channel 3
    set_data(0, 16'h0101); set_data(1, 16'h2222);
    set_data(2, 16'h3333); set_data(3, 16'hC444);
    ch_valid = 4'b1111;
    #1;
    check("bp_grant", 32'(ch_ready), 32'h8);
    push(3, 16'hC444, 16'h5A5A);
    tick();
    wait_start(0);
    finish_txn(2, 10, 1'b0);
    ch_valid = '0;

    // Reset while waiting on the engine, then a late eng_done
    ch_valid = 4'b0010;
    #1;
    check("ch1_ready", 32'(ch_ready), 32'h2);
    push(1, 16'h2222, 16'h0000);
    tick();
    ch_valid = '0;
    wait_start(0);
    tick();
    check("in_wait_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    eng_done = 1'b1; eng_result = 16'h7777;
    check_reset_outputs("mid_reset");
    tick();
    eng_done = 1'b0;
    check("late_done_valid", 32'(out_valid), 32'h0);
    check("late_done_busy",  32'(busy),      32'h0);

    // Continuous requests: order 0,1,2,3,0 with starts 4+elat cycles apart
    set_data(0, 16'h0A00); set_data(1, 16'h0B11);
    set_data(2, 16'hFC22); set_data(3, 16'h0D33);
    ch_valid = 4'b1111;
    #1;
    check("post_reset_grant", 32'(ch_ready), 32'h1);
    push(0, 16'h0A00, 16'h1000);
    push(1, 16'h0B11, 16'h1001);
    push(2, 16'hFC22, 16'h9002);
    push(3, 16'h0D33, 16'h1003);
    push(0, 16'h0A00, 16'h1004);
    tick();
    for (int k = 0; k < 5; k++) begin
      wait_start((k == 0) ? 0 : 6);
      finish_txn(2, 0, 1'b0);
    end
    ch_valid = '0;

`ifdef FIR_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog drops the sample and moves on to channel 1
    ch_valid = 4'b0100;
    push(2, 16'hFC22, 16'h0000);
    tick();
    ch_valid = 4'b0010;
    wait_start(0);
    tick();
    begin
      int n = 0;
      while (!timeout_err && n < 200) begin
        tick();
        n++;
      end
      $display("[%0d] timeout_err after %0d WAIT cycles", cyc, n);
      check("timeout_seen",   32'(timeout_err), 32'h1);
      check("timeout_cycles", 32'(n),           32'd64);
    end
    check("timeout_busy",  32'(busy),      32'h0);
    check("timeout_valid", 32'(out_valid), 32'h0);
    check("timeout_next",  32'(ch_ready),  32'h2);
    push(1, 16'h0B11, 16'h4321);
    wait_start(0);
    ch_valid = '0;
    finish_txn(0, 0, 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of input channels sharing one FIR engine.
REQ-002 Parameter DW, default 16: sample and result width, signed.
REQ-003 Parameter TIMEOUT, default 64: engine wait limit in cycles; used only with FIR_SCHED_TIMEOUT_EN.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 ch_valid  input  NCH  per-channel sample-valid.
REQ-007 ch_data  input  NCH*DW  channel k sample in bits [k*DW +: DW].
REQ-008 ch_ready  output  NCH  per-channel accept, one-hot or zero.
REQ-009 eng_start  output  1  one-cycle start pulse to the FIR engine.
REQ-010 eng_ch  output  clog2(NCH)  channel index for the engine's delay-line/state bank.
REQ-011 eng_data  output  DW  sample presented to the engine.
REQ-012 eng_done  input  1  engine result-valid pulse.
REQ-013 eng_result  input  DW  engine output sample.
REQ-014 out_valid  output  1  result-valid toward downstream.
REQ-015 out_ch  output  clog2(NCH)  channel of out_data.
REQ-016 out_data  output  DW  filtered sample.
REQ-017 out_ready  input  1  downstream accept.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, OUTPUT; exactly one engine operation in flight at any time.
REQ-020 IDLE: grant = first channel with ch_valid set, searching round-robin from last_grant+1 modulo NCH; ch_ready[grant] is driven combinationally high in the same cycle.
REQ-021 IDLE: a transfer occurs when ch_valid[g] and ch_ready[g] are both high; the block latches channel and data and moves to ISSUE; with no valid channel it stays in IDLE and ch_ready is zero.
REQ-022 ISSUE: eng_start high for exactly one cycle; eng_ch and eng_data hold the latched values from ISSUE through WAIT; next state is WAIT.
REQ-023 WAIT: on eng_done, latch eng_result into out_data and move to OUTPUT; eng_done is ignored in every other state.
REQ-024 OUTPUT: out_valid held high with stable out_ch/out_data until out_ready is high; on that cycle last_grant is updated to the served channel and the FSM moves to IDLE.
REQ-025 Latency: accept at cycle N gives eng_start at N+1; out_valid rises the cycle after eng_done; minimum accept-to-accept spacing is 4 cycles.
REQ-026 ch_ready is zero in ISSUE, WAIT and OUTPUT; ch_valid is not required to remain asserted while ch_ready is low.
REQ-027 Fairness: with all channels continuously valid, service order is 0,1,...,NCH-1,0,... with no channel skipped.
REQ-028 Data passes through unmodified, with no width change, truncation or sign change.

Reset
REQ-029 Reset puts the FSM in IDLE and sets ch_ready=0, eng_start=0, out_valid=0, busy=0, out_data=0, out_ch=0, eng_ch=0, eng_data=0, and last_grant=NCH-1 so channel 0 has first priority.
REQ-030 Reset asserted mid-operation aborts the operation: the in-flight sample is dropped and any eng_done arriving after reset is ignored.

Configuration
REQ-031 Macro FIR_SCHED_TIMEOUT_EN defined: a WAIT-state counter runs; if TIMEOUT cycles pass without eng_done, output timeout_err (1 bit) pulses for one cycle, the sample is dropped, last_grant advances, and the FSM returns to IDLE.
REQ-032 Macro FIR_SCHED_TIMEOUT_EN undefined: there is no counter and no timeout_err port, and WAIT persists indefinitely.

Verification
REQ-033 Single request: ch_valid=0001, ch0 data=0x1234, engine done 5 cycles after start with result 0x0ABC -> one eng_start with eng_ch=0 and eng_data=0x1234, then out_valid with out_ch=0 and out_data=0x0ABC.
REQ-034 All four channels valid continuously, out_ready=1 -> grants in order 0,1,2,3,0, each eng_start 4+engine-latency cycles apart.
REQ-035 Backpressure: out_ready=0 for 10 cycles in OUTPUT -> out_valid/out_data stable, ch_ready=0, no eng_start during the 10 cycles.
REQ-036 Spurious eng_done in IDLE and ISSUE -> ignored, with no out_valid.
REQ-037 Reset asserted in WAIT followed by a late eng_done -> all outputs at reset values, no out_valid, and the next grant goes to channel 0.
REQ-038 With FIR_SCHED_TIMEOUT_EN and TIMEOUT=64, no eng_done -> timeout_err pulses 64 cycles after entry to WAIT, the FSM returns to IDLE, and the next-valid channel is served.
